// File: rtl/uart_pkg.sv
// Shared types and constants for the UART command frame assembler.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE,
    HIGH,
    LOW
  } asm_state_t;

  localparam int unsigned FRAME_BYTES = 3;

endpackage

// File: rtl/uart_cmd_assembler_byte_gap_timer.sv
// Inter-byte gap counter; flags expiry when a partial frame has waited too long.
module byte_gap_timer #(
  parameter int unsigned TIMEOUT_CYCLES = 131072,
  parameter int unsigned TO_W           = 17
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam logic [TO_W-1:0] LAST = TO_W'(TIMEOUT_CYCLES - 1);

  logic [TO_W-1:0] cnt;

  assign expired = en && (cnt == LAST);

  // Expiry always coincides with clr from the owner, so the count never wraps.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + TO_W'(1);
    end
  end

endmodule

// File: rtl/uart_cmd_assembler.sv
// Assembles {cmd, data_hi, data_lo} byte frames from the UART receiver into a
// 24-bit command, with a gap timeout that drops stale partial frames.
module uart_cmd_assembler
  import uart_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 131072,
  parameter int unsigned TO_W           = 17
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx_rdy,
  input  logic [7:0]  rx_data,
  input  logic        clr_cmd_rdy,
  output logic        clr_rx_rdy,
  output logic [7:0]  cmd,
  output logic [15:0] data,
  output logic        cmd_rdy,
  output logic        frame_to
);

  asm_state_t state, state_nxt;
  logic ld_cmd, ld_hi, ld_lo;
  logic in_frame, gap_expired, gap_clr;

  assign in_frame = (state == HIGH) || (state == LOW);
  assign gap_clr  = (state == IDLE) || rx_rdy || gap_expired;

  byte_gap_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
    .TO_W          (TO_W)
  ) u_gap (
    .clk    (clk),
    .rst    (rst),
    .clr    (gap_clr),
    .en     (in_frame),
    .expired(gap_expired)
  );

  assign clr_rx_rdy = rx_rdy && !frame_to;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // An accept in the expiry cycle takes precedence, so frame_to is gated by rx_rdy.
  always_comb begin
    state_nxt = state;
    ld_cmd    = 1'b0;
    ld_hi     = 1'b0;
    ld_lo     = 1'b0;
    frame_to  = 1'b0;
    unique case (state)
      IDLE: begin
        if (rx_rdy) begin
          ld_cmd    = 1'b1;
          state_nxt = HIGH;
        end
      end
      HIGH: begin
        if (rx_rdy) begin
          ld_hi     = 1'b1;
          state_nxt = LOW;
        end else if (gap_expired) begin
          frame_to  = 1'b1;
          state_nxt = IDLE;
        end
      end
      LOW: begin
        if (rx_rdy) begin
          ld_lo     = 1'b1;
          state_nxt = IDLE;
        end else if (gap_expired) begin
          frame_to  = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cmd  <= '0;
      data <= '0;
    end else begin
      if (ld_cmd) cmd        <= rx_data;
      if (ld_hi)  data[15:8] <= rx_data;
      if (ld_lo)  data[7:0]  <= rx_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cmd_rdy <= 1'b0;
    end else if (ld_lo) begin
      cmd_rdy <= 1'b1;
    end else if (ld_cmd) begin
      cmd_rdy <= 1'b0;
    end else if (clr_cmd_rdy) begin
      cmd_rdy <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_cmd_assembler.sv
// Directed bench for uart_cmd_assembler with a frame scoreboard and running monitors.
module tb_uart_cmd_assembler;
  import uart_pkg::*;

  localparam int unsigned TO_CYC = 100;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rx_rdy = 1'b0;
  logic [7:0]  rx_data = '0;
  logic        clr_cmd_rdy = 1'b0;
  logic        clr_rx_rdy;
  logic [7:0]  cmd;
  logic [15:0] data;
  logic        cmd_rdy;
  logic        frame_to;

  int total = 0;
  int bad   = 0;
  logic [23:0] sb_q[$];
  int clr_cnt = 0;
  int acc_cnt = 0;
  logic clr_prev = 1'b0;
  logic rdy_prev = 1'b0;

  uart_cmd_assembler #(
    .TIMEOUT_CYCLES(TO_CYC),
    .TO_W          (7)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .rx_rdy     (rx_rdy),
    .rx_data    (rx_data),
    .clr_cmd_rdy(clr_cmd_rdy),
    .clr_rx_rdy (clr_rx_rdy),
    .cmd        (cmd),
    .data       (data),
    .cmd_rdy    (cmd_rdy),
    .frame_to   (frame_to)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Monitors sample on the falling edge, well away from the active edge.
  always @(negedge clk) begin
    check("clr_needs_rdy", clr_rx_rdy & ~rx_rdy, 0);
    check("clr_width", clr_rx_rdy & clr_prev, 0);
    if (clr_rx_rdy) clr_cnt++;
    if (rst || frame_to) acc_cnt = 0;
    if (cmd_rdy && !rdy_prev) begin
      check("three_accepts", (acc_cnt >= FRAME_BYTES) ? 1 : 0, 1);
      acc_cnt = 0;
      if (sb_q.size() == 0) begin
        check("sb_spurious", 1, 0);
      end else begin
        logic [23:0] e;
        e = sb_q.pop_front();
        check("sb_cmd", {24'h0, cmd}, {24'h0, e[23:16]});
        check("sb_data", {16'h0, data}, {16'h0, e[15:0]});
      end
    end
    if (clr_rx_rdy && !rst) acc_cnt++;
    clr_prev = clr_rx_rdy;
    rdy_prev = cmd_rdy;
  end

  task automatic send_byte(input logic [7:0] b, input logic with_clr);
    @(posedge clk);
    #1;
    rx_rdy      = 1'b1;
    rx_data     = b;
    clr_cmd_rdy = with_clr;
    #1;
    check("ack_comb", clr_rx_rdy, 1);
    @(posedge clk);
    #1;
    rx_rdy      = 1'b0;
    rx_data     = 8'($urandom);
    clr_cmd_rdy = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] c, input logic [7:0] h, input logic [7:0] l,
                            input int gap);
    send_byte(c, 1'b0);
    repeat (gap) @(posedge clk);
    send_byte(h, 1'b0);
    repeat (gap) @(posedge clk);
    sb_q.push_back({c, h, l});
    send_byte(l, 1'b0);
  endtask

  initial begin
    #2000000;
    $error("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "test done: total=%0d bad=%0d", total, bad + 1);
  end

  initial begin
    int c0;
    #23;
    check("rst_cmd", {24'h0, cmd}, 0);
    check("rst_data", {16'h0, data}, 0);
    check("rst_cmd_rdy", cmd_rdy, 0);
    check("rst_frame_to", frame_to, 0);
    check("rst_clr_rx", clr_rx_rdy, 0);
    @(posedge clk);
    #1 rst = 1'b0;

    // 1: basic frame with long gaps
    c0 = clr_cnt;
    send_frame(8'h05, 8'h12, 8'h34, 50);
    check("t1_cmd_rdy", cmd_rdy, 1);
    check("t1_cmd", {24'h0, cmd}, 32'h05);
    check("t1_data", {16'h0, data}, 32'h1234);
    check("t1_clr_pulses", clr_cnt - c0, 3);

    // 2: consumer clears cmd_rdy
    @(posedge clk);
    #1 clr_cmd_rdy = 1'b1;
    @(posedge clk);
    #1 clr_cmd_rdy = 1'b0;
    check("t2_cmd_rdy", cmd_rdy, 0);
    check("t2_cmd", {24'h0, cmd}, 32'h05);
    check("t2_data", {16'h0, data}, 32'h1234);

    // 3: gap timeout after a lone cmd byte
    send_byte(8'h07, 1'b0);
    for (int i = 1; i <= int'(TO_CYC); i++) begin
      check($sformatf("t3_frame_to_c%0d", i), frame_to, (i == int'(TO_CYC)) ? 1 : 0);
      if (i < int'(TO_CYC)) begin
        @(posedge clk);
        #1;
      end
    end
    @(posedge clk);
    #1;
    check("t3_frame_to_drop", frame_to, 0);
    check("t3_cmd_rdy", cmd_rdy, 0);
    check("t3_cmd", {24'h0, cmd}, 32'h07);
    check("t3_data_kept", {16'h0, data}, 32'h1234);
    send_frame(8'h08, 8'hAB, 8'hCD, 2);
    check("t3_new_rdy", cmd_rdy, 1);
    check("t3_new_data", {16'h0, data}, 32'hABCD);

    // 4: clr_cmd_rdy coincident with final accept
    send_byte(8'h10, 1'b0);
    send_byte(8'h22, 1'b0);
    sb_q.push_back(24'h102233);
    send_byte(8'h33, 1'b1);
    check("t4_set_wins", cmd_rdy, 1);

    // 5: overrun, new frame starts while cmd_rdy is still high
    send_frame(8'h21, 8'h43, 8'h65, 3);
    check("t5_a_rdy", cmd_rdy, 1);
    send_byte(8'h31, 1'b0);
    check("t5_drop_rdy", cmd_rdy, 0);
    check("t5_b_cmd", {24'h0, cmd}, 32'h31);
    send_byte(8'h87, 1'b0);
    sb_q.push_back(24'h3187_9A);
    send_byte(8'h9A, 1'b0);
    check("t5_b_rdy", cmd_rdy, 1);
    check("t5_b_data", {16'h0, data}, 32'h879A);

    // 6: asynchronous reset mid-frame
    send_byte(8'h41, 1'b0);
    send_byte(8'h52, 1'b0);
    rst = 1'b1;
    #1;
    check("t6_rst_cmd", {24'h0, cmd}, 0);
    check("t6_rst_data", {16'h0, data}, 0);
    check("t6_rst_rdy", cmd_rdy, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    send_frame(8'h61, 8'h72, 8'h83, 1);
    check("t6_rdy", cmd_rdy, 1);
    check("t6_cmd", {24'h0, cmd}, 32'h61);
    check("t6_data", {16'h0, data}, 32'h7283);

    repeat (3) @(posedge clk);
    #1;
    check("sb_empty", sb_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
